regfile_scoreboard: RTL and testbench

- 32 x 32-bit general-purpose register file with a per-register pending-write scoreboard.
- Consumes the 5-bit destination register number chosen by the decode-stage destination select (rt/rd). Tracks that number from issue to write-back.
- Provides two read ports with write-through bypass and a Stall output for the issue stage.
- Sits between decode/issue and write-back in the CPU datapath.

---
 rtl/regfile_scoreboard.sv | 86 ++++++++
 tb/tb_regfile_scoreboard.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// 32 x DW register file with a per-register pending-write scoreboard,
// two bypassed read ports and an issue-stage stall.
module regfile_scoreboard #(
  parameter int DW   = 32,
  parameter int NREG = 32
) (
  input  logic          Clk,
  input  logic          Clrn,
  input  logic [4:0]    Ra1,
  input  logic [4:0]    Ra2,
  input  logic          Use1,
  input  logic          Use2,
  output logic [DW-1:0] Qa,
  output logic [DW-1:0] Qb,
  input  logic          Issue,
  input  logic [4:0]    IssueWn,
  output logic          Stall,
  input  logic          Wb,
  input  logic [4:0]    Wn,
  input  logic [DW-1:0] D,
  output logic [5:0]    OutCnt,
  output logic          WbOrphan
);

  logic [DW-1:0]   regs_q [NREG];
  logic [DW-1:0]   regs_d [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [5:0]      out_cnt_q, out_cnt_d;
  logic            orphan_q, orphan_d;

  logic wb_hit, haz1, haz2, hazw, stall, acc, dec;

  // A write-back in the same cycle retires the hazard it would otherwise cause.
  always_comb begin
    wb_hit = Wb && (Wn != 5'd0);
    haz1   = (Ra1 != 5'd0) && busy_q[Ra1] && !(Wb && (Wn == Ra1));
    haz2   = (Ra2 != 5'd0) && busy_q[Ra2] && !(Wb && (Wn == Ra2));
    hazw   = (IssueWn != 5'd0) && busy_q[IssueWn] && !(Wb && (Wn == IssueWn));
    stall  = Issue && ((Use1 && haz1) || (Use2 && haz2) || hazw);
    acc    = Issue && !stall && (IssueWn != 5'd0);
    dec    = wb_hit && busy_q[Wn];

    busy_d = busy_q;
    if (wb_hit) busy_d[Wn] = 1'b0;
    if (acc) busy_d[IssueWn] = 1'b1;
    busy_d[0] = 1'b0;

    regs_d = regs_q;
    if (wb_hit) regs_d[Wn] = D;

    out_cnt_d = out_cnt_q;
    if (acc && !dec) out_cnt_d = out_cnt_q + 6'd1;
    else if (dec && !acc) out_cnt_d = out_cnt_q - 6'd1;

    orphan_d = orphan_q | (wb_hit && !busy_q[Wn]);
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      busy_q    <= '0;
      out_cnt_q <= '0;
      orphan_q  <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      busy_q    <= busy_d;
      out_cnt_q <= out_cnt_d;
      orphan_q  <= orphan_d;
    end
  end

  always_comb begin
    if (Ra1 == 5'd0) Qa = '0;
    else if (Wb && (Wn == Ra1)) Qa = D;
    else Qa = regs_q[Ra1];

    if (Ra2 == 5'd0) Qb = '0;
    else if (Wb && (Wn == Ra2)) Qb = D;
    else Qb = regs_q[Ra2];
  end

  assign Stall    = stall;
  assign OutCnt   = out_cnt_q;
  assign WbOrphan = orphan_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed vector table, hand
// sequences for reset and counter load, then random traffic against a model.
module tb_regfile_scoreboard;

  logic        clk, clrn;
  logic [4:0]  ra1, ra2, issue_wn, wn;
  logic        use1, use2, issue, wb;
  logic [31:0] d;
  logic [31:0] qa, qb;
  logic        stall, wb_orphan;
  logic [5:0]  out_cnt;

  int testsRun = 0;
  int failures = 0;

  regfile_scoreboard #(.DW(32), .NREG(32)) dut (
    .Clk(clk), .Clrn(clrn),
    .Ra1(ra1), .Ra2(ra2), .Use1(use1), .Use2(use2),
    .Qa(qa), .Qb(qb),
    .Issue(issue), .IssueWn(issue_wn), .Stall(stall),
    .Wb(wb), .Wn(wn), .D(d),
    .OutCnt(out_cnt), .WbOrphan(wb_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain register/busy arrays, count derived by popcount.
  logic [31:0] mReg [32];
  bit          mBusy [32];
  bit          mOrphan;

  task automatic modelReset();
    for (int i = 0; i < 32; i++) begin
      mReg[i]  = '0;
      mBusy[i] = 1'b0;
    end
    mOrphan = 1'b0;
  endtask

  function automatic int modelCount();
    int n = 0;
    for (int i = 1; i < 32; i++) if (mBusy[i]) n++;
    return n;
  endfunction

  function automatic bit modelHaz(input logic [4:0] r);
    return (r != 0) && mBusy[r] && !(wb && wn == r);
  endfunction

  function automatic bit modelStall();
    return issue && ((use1 && modelHaz(ra1)) || (use2 && modelHaz(ra2)) || modelHaz(issue_wn));
  endfunction

  function automatic logic [31:0] modelRead(input logic [4:0] ra);
    if (ra == 0) return 32'h0;
    if (wb && wn == ra) return d;
    return mReg[ra];
  endfunction

  task automatic modelCommit();
    bit accepted;
    accepted = issue && !modelStall() && issue_wn != 0;
    if (wb && wn != 0) begin
      if (!mBusy[wn]) mOrphan = 1'b1;
      mBusy[wn] = 1'b0;
      mReg[wn]  = d;
    end
    if (accepted) mBusy[issue_wn] = 1'b1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] a1, input logic [4:0] a2, input logic u1, input logic u2,
                               input logic iss, input logic [4:0] iwn,
                               input logic w, input logic [4:0] wnum, input logic [31:0] wd);
    ra1 = a1; ra2 = a2; use1 = u1; use2 = u2;
    issue = iss; issue_wn = iwn;
    wb = w; wn = wnum; d = wd;
  endtask

  task automatic idle();
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
  endtask

  // Inputs are set at posedge+1; combinational checks at posedge+4; state checks at next posedge+1.
  task automatic modelCycle();
    #3;
    checkOutput("model_qa", qa, modelRead(ra1));
    checkOutput("model_qb", qb, modelRead(ra2));
    checkOutput("model_stall", {31'b0, stall}, {31'b0, modelStall()});
    modelCommit();
    @(posedge clk); #1;
    checkOutput("model_outcnt", {26'b0, out_cnt}, modelCount());
    checkOutput("model_orphan", {31'b0, wb_orphan}, {31'b0, mOrphan});
  endtask

  typedef struct {
    logic [4:0]  ra1, ra2;
    logic        use1, use2, issue;
    logic [4:0]  issue_wn;
    logic        wb;
    logic [4:0]  wn;
    logic [31:0] d;
    logic [31:0] exp_qa, exp_qb;
    logic        exp_stall;
    logic [5:0]  exp_cnt;
    logic        exp_orphan;
  } vec_t;

  function automatic vec_t mk(input logic [4:0] a1, input logic [4:0] a2, input logic u1, input logic u2,
                              input logic iss, input logic [4:0] iwn,
                              input logic w, input logic [4:0] wnum, input logic [31:0] wd,
                              input logic [31:0] eqa, input logic [31:0] eqb, input logic est,
                              input logic [5:0] ecnt, input logic eorph);
    vec_t v;
    v.ra1 = a1; v.ra2 = a2; v.use1 = u1; v.use2 = u2; v.issue = iss; v.issue_wn = iwn;
    v.wb = w; v.wn = wnum; v.d = wd;
    v.exp_qa = eqa; v.exp_qb = eqb; v.exp_stall = est; v.exp_cnt = ecnt; v.exp_orphan = eorph;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    vecs.push_back(mk(0, 0, 0, 0, 1, 5,  0, 0, 32'h0,        32'h0,        32'h0,  0, 1, 0));
    vecs.push_back(mk(5, 0, 0, 0, 0, 0,  1, 5, 32'h1234,     32'h1234,     32'h0,  0, 0, 0));
    vecs.push_back(mk(5, 0, 1, 1, 1, 0,  0, 0, 32'h0,        32'h1234,     32'h0,  0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0,  1, 0, 32'hFFFFFFFF, 32'h0,        32'h0,  0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 7,  0, 0, 32'h0,        32'h0,        32'h0,  0, 1, 0));
    vecs.push_back(mk(7, 0, 1, 0, 1, 8,  0, 0, 32'h0,        32'h0,        32'h0,  1, 1, 0));
    vecs.push_back(mk(7, 0, 1, 0, 1, 8,  0, 0, 32'h0,        32'h0,        32'h0,  1, 1, 0));
    vecs.push_back(mk(7, 0, 1, 0, 1, 8,  1, 7, 32'hCAFE0001, 32'hCAFE0001, 32'h0,  0, 1, 0));
    vecs.push_back(mk(7, 8, 0, 0, 0, 0,  0, 0, 32'h0,        32'hCAFE0001, 32'h0,  0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 8,  0, 0, 32'h0,        32'h0,        32'h0,  1, 1, 0));
    vecs.push_back(mk(0, 8, 0, 0, 1, 8,  1, 8, 32'h88,       32'h0,        32'h88, 0, 1, 0));
    vecs.push_back(mk(0, 8, 0, 0, 0, 0,  1, 8, 32'h99,       32'h0,        32'h99, 0, 0, 0));
    vecs.push_back(mk(9, 0, 0, 0, 0, 0,  1, 9, 32'h55,       32'h55,       32'h0,  0, 0, 1));
    vecs.push_back(mk(9, 8, 0, 0, 0, 0,  0, 0, 32'h0,        32'h55,       32'h99, 0, 0, 1));

    idle();
    clrn = 1'b0;
    modelReset();
    #2;
    checkOutput("reset_qa", qa, 32'h0);
    checkOutput("reset_stall", {31'b0, stall}, 32'h0);
    checkOutput("reset_outcnt", {26'b0, out_cnt}, 32'h0);
    checkOutput("reset_orphan", {31'b0, wb_orphan}, 32'h0);
    #6 clrn = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].ra1, vecs[i].ra2, vecs[i].use1, vecs[i].use2, vecs[i].issue,
                    vecs[i].issue_wn, vecs[i].wb, vecs[i].wn, vecs[i].d);
      #3;
      checkOutput($sformatf("vec%0d_qa", i), qa, vecs[i].exp_qa);
      checkOutput($sformatf("vec%0d_qb", i), qb, vecs[i].exp_qb);
      checkOutput($sformatf("vec%0d_stall", i), {31'b0, stall}, {31'b0, vecs[i].exp_stall});
      modelCommit();
      @(posedge clk); #1;
      checkOutput($sformatf("vec%0d_outcnt", i), {26'b0, out_cnt}, {26'b0, vecs[i].exp_cnt});
      checkOutput($sformatf("vec%0d_orphan", i), {31'b0, wb_orphan}, {31'b0, vecs[i].exp_orphan});
    end

    // Asynchronous reset between edges with a pending write and sticky orphan.
    applyStimulus(0, 0, 0, 0, 1, 6, 0, 0, 32'h0);
    modelCycle();
    idle();
    ra1 = 5'd5;
    #1;
    checkOutput("prereset_qa", qa, 32'h1234);
    checkOutput("prereset_outcnt", {26'b0, out_cnt}, 32'd1);
    clrn = 1'b0;
    #1;
    checkOutput("async_reset_qa", qa, 32'h0);
    checkOutput("async_reset_outcnt", {26'b0, out_cnt}, 32'h0);
    checkOutput("async_reset_orphan", {31'b0, wb_orphan}, 32'h0);
    #1 clrn = 1'b1;
    modelReset();
    @(posedge clk); #1;

    // Fill every register, then retire them one by one.
    for (int r = 1; r < 32; r++) begin
      applyStimulus(0, 0, 0, 0, 1, 5'(r), 0, 0, 32'h0);
      modelCycle();
    end
    checkOutput("load_full_outcnt", {26'b0, out_cnt}, 32'd31);
    applyStimulus(0, 0, 1, 0, 1, 0, 1, 31, 32'h3100_0031);
    modelCycle();
    checkOutput("load_after_wb31_outcnt", {26'b0, out_cnt}, 32'd30);
    for (int r = 1; r < 31; r++) begin
      applyStimulus(5'(r), 0, 0, 0, 0, 0, 1, 5'(r), 32'hA000_0000 + 32'(r));
      modelCycle();
    end
    checkOutput("load_drained_outcnt", {26'b0, out_cnt}, 32'd0);
    checkOutput("load_no_orphan", {31'b0, wb_orphan}, 32'd0);

    // Random traffic on a small register window so hazards are frequent.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] rwn;
      rwn = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) begin
        for (int k = 0; k < 8; k++) begin
          if (mBusy[(int'(rwn) + k) % 8]) begin
            rwn = 5'((int'(rwn) + k) % 8);
            break;
          end
        end
      end
      applyStimulus(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                    1'($urandom_range(0, 2) == 0), rwn, $urandom);
      modelCycle();
    end

    idle();
    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
